// File: rtl/mem_stage_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : Memory-stage load/store unit. Takes the EX/MEM register
//               outputs and runs one req/gnt/rvalid data-bus transaction per
//               memory instruction. It generates byte enables and
//               lane-replicated store data, and sign/zero-extends load data.
//               It also holds the pipeline stalled until the response
//               arrives.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               alu_result_i          - effective address
//               rs2_i                 - store data, LSB-justified
//               lsu_op_i              - funct3 (B/H/W/BU/HU)
//               data_dest_i           - == DEST_MEM marks a load
//               mem_wr_sig_i          - store
//               stall_o               - hold EX/MEM and earlier stages
//               load_data_o           - extended load result (held)
//               done_o/misalign_o/bus_err_o - single-cycle status pulses
//               dmem_*                - data-bus request/response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [1:0] DEST_MEM       = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_i,
    input  logic [2:0]  lsu_op_i,
    input  logic [1:0]  data_dest_i,
    input  logic        mem_wr_sig_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        done_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int c_CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_TO_LAST);
    localparam logic c_TO_EN = (TIMEOUT_CYCLES > 0);

    logic [1:0]         r_state;
    logic [31:0]        r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic               r_we;
    logic [2:0]         r_op;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_load_data;
    logic               r_misalign;

    logic        w_access;
    logic        w_misaligned;
    logic        w_start;
    logic        w_timeout;
    logic        w_in_req;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;

    // Request decode. A store takes precedence when both flags are set,
    // which only matters for r_we below.
    assign w_access = mem_wr_sig_i | (data_dest_i == DEST_MEM);

    // lsu_op[1:0] selects the size: 00 byte, 01 half, anything else word.
    // This folds the unused codes 011/110/111 onto word accesses.
    assign w_misaligned = ((lsu_op_i[1:0] == 2'b01) & alu_result_i[0])
                        | (lsu_op_i[1]              & (|alu_result_i[1:0]));

    assign w_start = (r_state == c_IDLE) & w_access & ~w_misaligned;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_i;
        case (lsu_op_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << alu_result_i[1:0];
                w_wdata = {4{rs2_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << alu_result_i[1:0];
                w_wdata = {2{rs2_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend it.
    assign w_shifted = dmem_rdata_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_ext = dmem_rdata_i;
        case (r_op[1:0])
            2'b00:   w_load_ext = r_op[2] ? {24'd0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_ext = r_op[2] ? {16'd0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: ;
        endcase
    end

    // A grant is not completion, so a grant on the last REQ cycle still times
    // out. An rvalid on the last WAIT cycle completes the access normally.
    assign w_timeout = c_TO_EN & (r_cnt == c_CNT_LAST)
                     & ((r_state == c_REQ) | ((r_state == c_WAIT) & ~dmem_rvalid_i));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_load_data <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_misalign <= (r_state == c_IDLE) & w_access & w_misaligned;
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_addr  <= alu_result_i;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_we    <= mem_wr_sig_i;
                        r_op    <= lsu_op_i;
                        r_cnt   <= '0;
                        r_state <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (w_timeout) begin
                        r_load_data <= '0;
                        r_state     <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (dmem_gnt_i) begin
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (dmem_rvalid_i) begin
                        if (!r_we) begin
                            r_load_data <= w_load_ext;
                        end
                        r_state <= c_DONE;
                    end else if (w_timeout) begin
                        r_load_data <= '0;
                        r_state     <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign w_in_req = (r_state == c_REQ);

    assign stall_o      = w_start | w_in_req | (r_state == c_WAIT);
    assign load_data_o  = r_load_data;
    assign done_o       = (r_state == c_DONE);
    assign misalign_o   = r_misalign;
    assign bus_err_o    = w_timeout;
    assign dmem_req_o   = w_in_req;
    assign dmem_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign dmem_we_o    = w_in_req & r_we;
    assign dmem_be_o    = w_in_req ? r_be : 4'd0;
    assign dmem_wdata_o = w_in_req ? r_wdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu. A transaction-level
//               model predicts every output on every cycle from the chosen
//               address, op and bus response delays. Directed accesses pin
//               the model to literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    localparam int         T  = 8;
    localparam logic [1:0] DM = 2'b01;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_i;
    logic [31:0] rs2_i;
    logic [2:0]  lsu_op_i;
    logic [1:0]  data_dest_i;
    logic        mem_wr_sig_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        done_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        dmem_req_o;
    logic        dmem_gnt_i;
    logic [31:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    mem_stage_lsu #(.TIMEOUT_CYCLES(T), .DEST_MEM(DM)) dut (
        .clk(clk), .reset(reset),
        .alu_result_i(alu_result_i), .rs2_i(rs2_i), .lsu_op_i(lsu_op_i),
        .data_dest_i(data_dest_i), .mem_wr_sig_i(mem_wr_sig_i),
        .stall_o(stall_o), .load_data_o(load_data_o), .done_o(done_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_addr_o(dmem_addr_o),
        .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_done, exp_err, exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata;
    logic [31:0] model_load = 32'd0;
    logic        pend_mis = 1'b0;

    // Per-access event counters and last bus request seen.
    int          n_stall, n_done, n_req, n_mis, n_err;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_o",      32'(stall_o),      32'(exp_stall));
            chk("dmem_req_o",   32'(dmem_req_o),   32'(exp_req));
            chk("dmem_addr_o",  dmem_addr_o,       exp_addr);
            chk("dmem_we_o",    32'(dmem_we_o),    32'(exp_we));
            chk("dmem_be_o",    32'(dmem_be_o),    32'(exp_be));
            chk("dmem_wdata_o", dmem_wdata_o,      exp_wdata);
            chk("done_o",       32'(done_o),       32'(exp_done));
            chk("bus_err_o",    32'(bus_err_o),    32'(exp_err));
            chk("misalign_o",   32'(misalign_o),   32'(exp_mis));
            chk("load_data_o",  load_data_o,       model_load);
            if (stall_o)    n_stall++;
            if (done_o)     n_done++;
            if (misalign_o) n_mis++;
            if (bus_err_o)  n_err++;
            if (dmem_req_o) begin
                n_req++;
                seen_addr  = dmem_addr_o;
                seen_be    = dmem_be_o;
                seen_we    = dmem_we_o;
                seen_wdata = dmem_wdata_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic [31:0] a, input logic [2:0] op);
        int sz  = size_of(op);
        int off = int'(a % 4);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] wdata_of(input logic [31:0] d, input logic [2:0] op);
        int sz = size_of(op);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] load_of(input logic [31:0] a, input logic [2:0] op,
                                            input logic [31:0] word);
        int sz  = size_of(op);
        int off = int'(a % 4);
        bit sgn = (op == 3'b000) || (op == 3'b001);
        logic [31:0] v = word >> (8 * off);
        if (sz == 1) begin
            v = v & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [1:0] non_dm();
        logic [1:0] dd = 2'($urandom_range(0, 2));
        if (dd == DM) dd = 2'b11;
        return dd;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step_cycle();
        @(posedge clk);
        #1;
        exp_mis   = pend_mis;
        pend_mis  = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_be = 4'd0;
        exp_addr  = 32'd0; exp_wdata = 32'd0; exp_done = 1'b0; exp_err = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = $urandom;
    endtask

    task automatic set_idle_inputs();
        alu_result_i = $urandom;
        rs2_i        = $urandom;
        lsu_op_i     = 3'($urandom);
        mem_wr_sig_i = 1'b0;
        data_dest_i  = non_dm();
    endtask

    // Bus signals are only sampled in REQ/WAIT, so noise here must be harmless.
    task automatic idle_cycle();
        step_cycle();
        set_idle_inputs();
        dmem_gnt_i    = 1'($urandom);
        dmem_rvalid_i = 1'($urandom);
    endtask

    // g: REQ cycles before the one carrying gnt; r: WAIT cycles before rvalid.
    // rst_at: REQ/WAIT cycle index in which reset is raised (0 = never).
    task automatic run_access(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                              input logic ld, input logic st, input int g, input int r,
                              input logic [31:0] rdata, input int rst_at);
        int  sz, n, last;
        bit  to, acc, mis;
        step_cycle();
        alu_result_i = a; rs2_i = d; lsu_op_i = op; mem_wr_sig_i = st;
        data_dest_i  = ld ? DM : non_dm();
        n_stall = 0; n_done = 0; n_req = 0; n_mis = 0; n_err = 0;
        sz  = size_of(op);
        acc = ld || st;
        mis = acc && ((a % sz) != 0);
        if (!acc) return;
        if (mis) begin
            pend_mis = 1'b1;
            return;
        end
        exp_stall = 1'b1;
        n    = g + r + 2;
        to   = (n > T);
        last = to ? T : n;
        for (int c = 1; c <= last; c++) begin
            step_cycle();
            exp_stall = 1'b1;
            if (c <= g + 1) begin
                exp_req   = 1'b1;
                exp_addr  = (a / 4) * 4;
                exp_we    = st;
                exp_be    = be_of(a, op);
                exp_wdata = wdata_of(d, op);
                dmem_gnt_i = (c == g + 1);
            end else if (c == n) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = rdata;
            end
            if (to && c == T) exp_err = 1'b1;
            if (c == rst_at) begin
                reset = 1'b1;
                step_cycle();
                reset = 1'b0;
                set_idle_inputs();
                dmem_rvalid_i = 1'b1;   // late response, must be ignored
                dmem_rdata_i  = rdata;
                model_load    = 32'd0;
                return;
            end
        end
        step_cycle();
        exp_done = 1'b1;
        if (to) model_load = 32'd0;
        else if (ld && !st) model_load = load_of(a, op, rdata);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b1;
        set_idle_inputs();
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
        step_cycle();
        set_idle_inputs();
        chk_en = 1'b1;
        step_cycle();
        set_idle_inputs();
        settle();
        chk("reset load_data", load_data_o, 32'd0);
        chk("reset stall", 32'(stall_o), 32'd0);
        reset = 1'b0;
        idle_cycle();

        // LW 0x100, immediate gnt and rvalid.
        run_access(32'h100, 32'h0, 3'b010, 1, 0, 0, 0, 32'hDEADBEEF, 0);
        settle();
        chk("LW stall cycles", n_stall, 3);
        chk("LW done pulses", n_done, 1);
        chk("LW load_data", load_data_o, 32'hDEADBEEF);

        // LB/LBU at 0x103: byte lane 3.
        run_access(32'h103, 32'h0, 3'b000, 1, 0, 0, 0, 32'h80123456, 0);
        settle();
        chk("LB be", 32'(seen_be), 32'h8);
        chk("LB load_data", load_data_o, 32'hFFFFFF80);
        run_access(32'h103, 32'h0, 3'b100, 1, 0, 1, 1, 32'h80123456, 0);
        settle();
        chk("LBU load_data", load_data_o, 32'h00000080);

        // SH 0x202: the store leaves load_data untouched.
        run_access(32'h202, 32'h1234ABCD, 3'b001, 0, 1, 0, 0, 32'hFFFFFFFF, 0);
        settle();
        chk("SH we", 32'(seen_we), 32'd1);
        chk("SH be", 32'(seen_be), 32'hC);
        chk("SH wdata", seen_wdata, 32'hABCDABCD);
        chk("SH addr", seen_addr, 32'h200);
        chk("SH load_data held", load_data_o, 32'h00000080);

        // Misaligned LW: rejected without touching the bus.
        run_access(32'h101, 32'h0, 3'b010, 1, 0, 0, 0, 32'h0, 0);
        idle_cycle();
        settle();
        chk("misalign pulses", n_mis, 1);
        chk("misalign reqs", n_req, 0);
        chk("misalign stalls", n_stall, 0);

        // Delayed gnt (3 REQ cycles) and rvalid (2 WAIT cycles): 1+3+2 stalls.
        run_access(32'h300, 32'h0, 3'b010, 1, 0, 2, 1, 32'h55AA55AA, 0);
        settle();
        chk("slow stall cycles", n_stall, 6);
        chk("slow req cycles", n_req, 3);
        chk("slow load_data", load_data_o, 32'h55AA55AA);

        // No gnt: bus error on the 8th REQ cycle, load data cleared.
        run_access(32'h400, 32'h0, 3'b010, 1, 0, 20, 0, 32'h0, 0);
        settle();
        chk("timeout err pulses", n_err, 1);
        chk("timeout req cycles", n_req, T);
        chk("timeout stall cycles", n_stall, T + 1);
        chk("timeout load_data", load_data_o, 32'd0);

        // Reset while waiting for rvalid.
        run_access(32'h504, 32'h0, 3'b010, 1, 0, 0, 0, 32'h12345678, 0);
        run_access(32'h500, 32'h0, 3'b010, 1, 0, 0, 10, 32'hCAFEF00D, 3);
        settle();
        chk("reset-in-wait load_data", load_data_o, 32'd0);
        chk("reset-in-wait req", 32'(dmem_req_o), 32'd0);
        idle_cycle();
        settle();
        chk("late rvalid done", 32'(done_o), 32'd0);

        // Randomized accesses.
        for (int it = 0; it < 250; it++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic        ld, st;
            int          k, g, r;
            op = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % size_of(op));
            k  = $urandom_range(0, 9);
            ld = (k >= 1 && k <= 5) || k == 9;
            st = (k >= 6);
            g  = $urandom_range(0, 3);
            r  = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) g = $urandom_range(5, 9);
            run_access(a, $urandom, op, ld, st, g, r, $urandom, 0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        idle_cycle();
        idle_cycle();
        settle();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
